// File: rtl/zbb_iter.sv
// Multi-cycle Zbb execution unit: ANDN/ORN/XNOR in one registered cycle,
// CLZ/CTZ/CPOP evaluated iteratively over STEP-bit chunks.
module zbb_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [6:0]      cmdOp,
  input  logic [2:0]      cmdF3,
  input  logic [6:0]      cmdF7,
  input  logic [4:0]      cmdRs2,
  input  logic [XLEN-1:0] din_rs1,
  input  logic [XLEN-1:0] din_rs2,
  output logic            isZbbInstr,
  output logic            ready,
  output logic            done,
  output logic            regWrite,
  output logic [XLEN-1:0] dout_rd
);

  localparam int unsigned K    = XLEN / STEP;
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  // Encoding matches the rs2 field of the count instructions.
  typedef enum logic [1:0] {OpClz = 2'd0, OpCtz = 2'd1, OpCpop = 2'd2} cop_e;

  state_e          state_q, state_d;
  cop_e            op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [XLEN-1:0] dout_q, dout_d;

  logic            is_logic, is_count;
  logic [XLEN-1:0] logic_res;

  // Instruction decode, purely from the current command fields.
  always_comb begin
    is_logic = (cmdOp == 7'b0110011) && (cmdF7 == 7'b0100000) &&
               ((cmdF3 == 3'b111) || (cmdF3 == 3'b110) || (cmdF3 == 3'b100));
    is_count = (cmdOp == 7'b0010011) && (cmdF3 == 3'b001) && (cmdF7 == 7'b0110000) &&
               (cmdRs2 <= 5'd2);
    isZbbInstr = is_logic | is_count;
  end

  // Single-cycle logic op result.
  always_comb begin
    case (cmdF3)
      3'b111:  logic_res = din_rs1 & ~din_rs2;
      3'b110:  logic_res = din_rs1 | ~din_rs2;
      default: logic_res = ~(din_rs1 ^ din_rs2);
    endcase
  end

  logic [STEP-1:0] chunk;
  logic [CntW-1:0] chunk_lz, chunk_tz, chunk_pop;
  logic            chunk_any, found_l, found_t;

  // Statistics of the chunk under examination. The operand register is shifted so
  // the current chunk is always at the top (CLZ) or bottom (CTZ/CPOP).
  always_comb begin
    chunk     = (op_q == OpClz) ? opnd_q[XLEN-1 -: STEP] : opnd_q[STEP-1:0];
    chunk_any = |chunk;
    chunk_lz  = CntW'(STEP);
    chunk_tz  = CntW'(STEP);
    chunk_pop = '0;
    found_l   = 1'b0;
    found_t   = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!found_l && chunk[i]) begin
        chunk_lz = CntW'(STEP - 1 - i);
        found_l  = 1'b1;
      end
    end
    for (int i = 0; i < STEP; i++) begin
      if (!found_t && chunk[i]) begin
        chunk_tz = CntW'(i);
        found_t  = 1'b1;
      end
      chunk_pop = chunk_pop + {{(CntW-1){1'b0}}, chunk[i]};
    end
  end

  logic [CntW-1:0] cnt_step;
  logic            finish;

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dout_d   = dout_q;
    cnt_step = '0;
    finish   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && isZbbInstr && !kill) begin
          if (is_logic) begin
            dout_d  = logic_res;
            state_d = StDone;
          end else begin
            op_d    = cop_e'(cmdRs2[1:0]);
            opnd_d  = din_rs1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          if (op_q == OpCpop) begin
            cnt_step = chunk_pop;
            finish   = (idx_q == IdxW'(K - 1));
          end else if (chunk_any) begin
            cnt_step = (op_q == OpClz) ? chunk_lz : chunk_tz;
            finish   = 1'b1;
          end else begin
            cnt_step = CntW'(STEP);
            finish   = (idx_q == IdxW'(K - 1));
          end
          cnt_d  = cnt_q + cnt_step;
          idx_d  = idx_q + 1'b1;
          opnd_d = (op_q == OpClz) ? (opnd_q << STEP) : (opnd_q >> STEP);
          if (finish) begin
            dout_d  = {{(XLEN-CntW){1'b0}}, cnt_d};
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpClz;
      opnd_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
    end
  end

  // Status outputs; a kill during DONE suppresses the write-back pulse.
  always_comb begin
    ready    = (state_q == StIdle);
    done     = (state_q == StDone) && !kill;
    regWrite = done;
    dout_rd  = dout_q;
  end

endmodule

// File: tb/tb_zbb_iter.sv
// Self-checking bench for zbb_iter: a 32/4 and a 64/8 instance checked against a
// behavioural model of the Zbb result and chunk-scan latency.
module tb_zbb_iter;

  logic        clk = 1'b0;
  logic        rst, kill, start_n, start_w;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rs2f;
  logic [63:0] a, b;

  logic        iz_n, rdy_n, done_n, rw_n;
  logic [31:0] dout_n;
  logic        iz_w, rdy_w, done_w, rw_w;
  logic [63:0] dout_w;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  zbb_iter #(.XLEN(32), .STEP(4)) u_dut_n (
    .clk(clk), .rst(rst), .start(start_n), .kill(kill),
    .cmdOp(op), .cmdF3(f3), .cmdF7(f7), .cmdRs2(rs2f),
    .din_rs1(a[31:0]), .din_rs2(b[31:0]),
    .isZbbInstr(iz_n), .ready(rdy_n), .done(done_n), .regWrite(rw_n), .dout_rd(dout_n)
  );

  zbb_iter #(.XLEN(64), .STEP(8)) u_dut_w (
    .clk(clk), .rst(rst), .start(start_w), .kill(kill),
    .cmdOp(op), .cmdF3(f3), .cmdF7(f7), .cmdRs2(rs2f),
    .din_rs1(a), .din_rs2(b),
    .isZbbInstr(iz_w), .ready(rdy_w), .done(done_w), .regWrite(rw_w), .dout_rd(dout_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Codes: 0 ANDN, 1 ORN, 2 XNOR, 3 CLZ, 4 CTZ, 5 CPOP.
  task automatic set_cmd(input int code);
    case (code)
      0, 1, 2: begin
        op   = 7'b0110011;
        f7   = 7'b0100000;
        f3   = (code == 0) ? 3'b111 : (code == 1) ? 3'b110 : 3'b100;
        rs2f = 5'($urandom);
      end
      default: begin
        op   = 7'b0010011;
        f7   = 7'b0110000;
        f3   = 3'b001;
        rs2f = 5'(code - 3);
      end
    endcase
  endtask

  function automatic logic [63:0] ref_res(input int code, input int xlen,
                                          input logic [63:0] ra, input logic [63:0] rb);
    logic [63:0] m;
    int n;
    m = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ra = ra & m;
    rb = rb & m;
    n = 0;
    case (code)
      0: return ra & ~rb & m;
      1: return (ra | ~rb) & m;
      2: return ~(ra ^ rb) & m;
      3: begin
        while (n < xlen && !ra[xlen-1-n]) n++;
        return 64'(n);
      end
      4: begin
        while (n < xlen && !ra[n]) n++;
        return 64'(n);
      end
      default: return 64'($countones(ra));
    endcase
  endfunction

  // Cycles from accept edge to done: logic 1; CPOP K+1; CLZ/CTZ chunk(1-based)+1.
  function automatic int ref_lat(input int code, input int xlen, input int step,
                                 input logic [63:0] ra);
    int r;
    if (code < 3) return 1;
    if (code == 5) return xlen / step + 1;
    r = int'(ref_res(code, xlen, ra, 64'd0));
    if (r == xlen) return xlen / step + 1;
    return r / step + 2;
  endfunction

  task automatic do_op(input string tag, input bit wide, input int code,
                       input logic [63:0] ra, input logic [63:0] rb,
                       input logic [63:0] exp_r, input int exp_l);
    int lat;
    bit got;
    logic [63:0] res;
    set_cmd(code);
    a = ra;
    b = rb;
    #1;
    check({tag, "_dec"}, wide ? iz_w : iz_n, 1'b1);
    if (wide) start_w = 1'b1; else start_n = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b0;
    start_w = 1'b0;
    // Operands and command must be ignored after acceptance.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    set_cmd(int'($urandom_range(0, 5)));
    lat = 1;
    while (!(wide ? done_w : done_n) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = wide ? done_w : done_n;
    res = wide ? dout_w : {32'd0, dout_n};
    check({tag, "_done"}, got, 1'b1);
    check({tag, "_res"}, res, exp_r);
    check({tag, "_lat"}, lat, exp_l);
    check({tag, "_rw"}, wide ? rw_w : rw_n, 1'b1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, wide ? done_w : done_n, 1'b0);
    check({tag, "_idle"}, wide ? rdy_w : rdy_n, 1'b1);
    res = wide ? dout_w : {32'd0, dout_n};
    check({tag, "_hold"}, res, exp_r);
  endtask

  task automatic rand_op(input bit wide);
    int code, xl, st;
    logic [63:0] ra, rb;
    xl   = wide ? 64 : 32;
    st   = wide ? 8 : 4;
    code = int'($urandom_range(0, 5));
    ra   = {$urandom, $urandom};
    rb   = {$urandom, $urandom};
    if (code >= 3) ra = ra >> $urandom_range(0, 63);
    if ($urandom_range(0, 7) == 0) ra = 64'd0;
    if (!wide) begin
      ra = ra & 64'hFFFF_FFFF;
      rb = rb & 64'hFFFF_FFFF;
    end
    do_op("rand", wide, code, ra, rb, ref_res(code, xl, ra, rb), ref_lat(code, xl, st, ra));
  endtask

  initial begin
    int lat, seen;
    bit exp_dec;
    rst = 1'b1; kill = 1'b0; start_n = 1'b0; start_w = 1'b0;
    a = '0; b = '0;
    set_cmd(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {rdy_n, rdy_w}, 2'b11);
    check("rst_done", {done_n, done_w, rw_n, rw_w}, 4'b0000);
    check("rst_dout", dout_w | {32'd0, dout_n}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("andn", 0, 0, 64'hF0F0_FFFF, 64'h0F0F_00FF, 64'hF0F0_FF00, 1);
    do_op("orn",  0, 1, 64'hF0F0_FFFF, 64'h0F0F_00FF, 64'hF0F0_FFFF, 1);
    do_op("xnor", 0, 2, 64'hF0F0_FFFF, 64'h0F0F_00FF, 64'h0000_00FF, 1);
    do_op("clz_msb", 0, 3, 64'h8000_0000, 64'd0, 64'd0, 2);
    do_op("clz_one", 0, 3, 64'h0000_0001, 64'd0, 64'd31, 9);
    do_op("clz_zero", 0, 3, 64'd0, 64'd0, 64'd32, 9);
    do_op("ctz_100", 0, 4, 64'h0000_0100, 64'd0, 64'd8, 4);
    do_op("ctz_zero", 0, 4, 64'd0, 64'd0, 64'd32, 9);
    do_op("cpop_ones", 0, 5, 64'hFFFF_FFFF, 64'd0, 64'd32, 9);
    do_op("cpop_mix", 0, 5, 64'h1234_5678, 64'd0, 64'd13, 9);
    do_op("w_clz_zero", 1, 3, 64'd0, 64'd0, 64'd64, 9);
    do_op("w_cpop_ones", 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd64, 9);
    do_op("w_ctz_top", 1, 4, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 9);
    do_op("w_andn", 1, 0, 64'hFFFF_0000_1234_5678, 64'h00FF_00FF_0000_FFFF,
          64'hFF00_0000_1234_0000, 1);

    for (int i = 0; i < 40; i++) rand_op(0);
    for (int i = 0; i < 15; i++) rand_op(1);

    // Start held during RUN with a different op: first result returned unchanged.
    set_cmd(5);
    a = 64'h1234_5678;
    start_n = 1'b1;
    @(posedge clk); #1;
    set_cmd(0);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 1;
    while (!done_n && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    start_n = 1'b0;
    check("busy_start_res", {32'd0, dout_n}, 64'd13);
    check("busy_start_lat", lat, 9);
    @(posedge clk); #1;
    check("busy_start_pulse", done_n, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Kill two cycles into CPOP.
    set_cmd(5);
    a = 64'hFFFF_FFFF;
    start_n = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_ready", rdy_n, 1'b1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_n) seen++;
      @(posedge clk); #1;
    end
    check("kill_no_done", seen, 0);
    check("kill_dout", {32'd0, dout_n}, 64'd13);

    // Kill together with start in IDLE: nothing accepted.
    set_cmd(0);
    a = 64'hFFFF_FFFF;
    b = 64'd0;
    start_n = 1'b1;
    kill = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b0;
    kill = 1'b0;
    check("kill_idle_ready", rdy_n, 1'b1);
    check("kill_idle_done", done_n, 1'b0);
    check("kill_idle_dout", {32'd0, dout_n}, 64'd13);

    // Kill during the DONE cycle suppresses the pulse.
    set_cmd(0);
    a = 64'hF0F0_FFFF;
    b = 64'h0F0F_00FF;
    start_n = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b0;
    kill = 1'b1;
    #1;
    check("kill_done_pulse", {done_n, rw_n}, 2'b00);
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_done_ready", rdy_n, 1'b1);
    check("kill_done_dout", {32'd0, dout_n}, 64'hF0F0_FF00);

    // Reset mid-RUN.
    set_cmd(3);
    a = 64'd1;
    start_n = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_ready", rdy_n, 1'b1);
    check("rst_run_done", {done_n, rw_n}, 2'b00);
    check("rst_run_dout", {32'd0, dout_n}, 64'd0);

    // Illegal encoding: no decode, no acceptance.
    op = 7'b0110011; f3 = 3'b111; f7 = 7'b0000000;
    #1;
    check("illegal_dec", {iz_n, iz_w}, 2'b00);
    start_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_n || !rdy_n) seen++;
    end
    start_n = 1'b0;
    check("illegal_ignored", seen, 0);

    // Random command fields against the decode table.
    for (int i = 0; i < 40; i++) begin
      op   = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
      f3   = 3'($urandom);
      f7   = ($urandom_range(0, 2) == 0) ? 7'($urandom) :
             (($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0110000);
      rs2f = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      exp_dec = ((op == 7'b0110011) && (f7 == 7'b0100000) &&
                 (f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b100)) ||
                ((op == 7'b0010011) && (f3 == 3'b001) && (f7 == 7'b0110000) &&
                 (rs2f == 5'd0 || rs2f == 5'd1 || rs2f == 5'd2));
      #1;
      check("dec_rand", {iz_n, iz_w}, {exp_dec, exp_dec});
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/zbb_iter.md
Name: zbb_iter

Overview:
Multi-cycle, parametrised Zbb execution unit. It succeeds the single-cycle combinational Zbb decoder/ALU.
- Logic ops (ANDN, ORN, XNOR) complete in one registered cycle.
- Count ops (CLZ, CTZ, CPOP) run iteratively over STEP-bit chunks, trading latency for area.
- Sits beside the main ALU. The core stalls on `ready`/`done` while a Zbb op is in flight.

Parameters:
- XLEN, 32, operand/result width; 32 or 64 only.
- STEP, 4, bits examined per iteration; power of two dividing XLEN; K = XLEN/STEP iterations max.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1 and isZbbInstr=1
- kill  in  1  abort in-flight op (pipeline flush)
- cmdOp  in  7  instr[6:0]
- cmdF3  in  3  instr[14:12]
- cmdF7  in  7  instr[31:25]
- cmdRs2  in  5  instr[24:20]; selects count op
- din_rs1  in  XLEN  operand A
- din_rs2  in  XLEN  operand B (logic ops only)
- isZbbInstr  out  1  combinational decode hit on current cmd* inputs
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; dout_rd valid
- regWrite  out  1  equals done
- dout_rd  out  XLEN  result, held until next accepted start

Behaviour:
- Decode:
  - op=0110011, F3=111, F7=0100000 -> ANDN (rs1 & ~rs2)
  - F3=110 -> ORN (rs1 | ~rs2)
  - F3=100 -> XNOR (~(rs1 ^ rs2))
  - op=0010011, F3=001, F7=0110000, rs2 field 00000/00001/00010 -> CLZ/CTZ/CPOP
  - anything else: isZbbInstr=0; start ignored
- Reset: state=IDLE, ready=1, done=0, regWrite=0, dout_rd=0, internal count/operand cleared.
- FSM IDLE -> RUN -> DONE -> IDLE.
- Accept edge E0 (IDLE, start=1, isZbbInstr=1, kill=0):
  - Logic op: dout_rd <= result; state <= DONE.
  - Count op: latch rs1 and op, clear count, clear chunk index; state <= RUN.
- RUN, one chunk per edge:
  - CLZ scans MSB chunk first; CTZ scans LSB chunk first.
  - Chunk with no set bit: count += STEP; advance.
  - CLZ/CTZ chunk containing first set bit: count += leading/trailing zeros within chunk; go to DONE (early exit).
  - CPOP: count += popcount(chunk); never exits early.
  - After chunk K is processed, go to DONE unconditionally.
  - On transition to DONE: dout_rd <= count zero-extended to XLEN. Count width is clog2(XLEN+1) bits, so the all-zeros result is XLEN exactly (32 or 64, no wrap).
- DONE: done=regWrite=1 for exactly one cycle; next edge -> IDLE.
- Latency, accept edge to done-high cycle, STEP=4, XLEN=32:
  - Logic: 1.
  - CPOP: K+1 = 9.
  - CLZ/CTZ: (index of chunk holding first one) + 1; zero operand gives 9.
- start while ready=0: ignored, no queuing.
- Inputs are sampled only at the accept edge; later changes to din_*/cmd* have no effect.
- kill:
  - In RUN or DONE: next state IDLE, done forced 0 that cycle, dout_rd unchanged.
  - kill with start in IDLE: kill wins, nothing accepted.
- rst mid-operation: same as reset values next edge; any result is lost.
- isZbbInstr is purely combinational and independent of state.

Test Plan:
- Reset, then ANDN rs1=0xF0F0_FFFF, rs2=0x0F0F_00FF -> done one cycle after accept, dout_rd=0xF0F0_FF00. ORN and XNOR with the same operands -> 0xF0F0_FFFF and 0x0000_00FF.
- CLZ: rs1=0x8000_0000 -> 0, latency 2; rs1=0x0000_0001 -> 31, latency 9; rs1=0 -> 32, latency 9.
- CTZ rs1=0x0000_0100 -> 8, latency 4 (third chunk). CPOP rs1=0xFFFF_FFFF -> 32 and rs1=0x1234_5678 -> 13, both latency 9.
- start asserted during RUN with a different op -> ignored; the first op's result is returned unchanged. Illegal encoding (op=0110011, F3=111, F7=0000000) -> isZbbInstr=0, ready stays 1, no done.
- kill two cycles into CPOP -> IDLE next edge, no done pulse, dout_rd keeps previous value. rst asserted during RUN -> all outputs at reset values next cycle.
- XLEN=64, STEP=8: CLZ 0 -> 64 with latency 9; CPOP of all-ones -> 64.
